// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU sequence driver.
package alu_pkg;

    localparam int DATA_W   = 8;
    localparam int OP_W     = 3;
    localparam int SEL_W    = 7;
    localparam int ALU_ST_W = 2;

    // Driver FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_CLEAR = 3'd4
    } state_t;

    // ALU input-register control codes.
    typedef enum logic [2:0] {
        IN_SEL_NONE    = 3'b000,
        IN_SEL_RESET   = 3'b001,
        IN_SEL_LOAD    = 3'b010,
        IN_SEL_PERSIST = 3'b100
    } in_sel_t;

    // ALU state code meaning "result valid".
    localparam logic [ALU_ST_W-1:0] ALU_RESULT_STATE = 2'b11;

    // Operation index that has no ALU function.
    localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

endpackage

// File: rtl/alu_op_decode.sv
// Operation index to one-hot ALU select: op n sets bit (6-n); op 7 gives 0.
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [OP_W-1:0]  op,
    output logic [SEL_W-1:0] onehot
);

    localparam logic [SEL_W-1:0] SEL_TOP = {1'b1, {(SEL_W-1){1'b0}}};

    // Shift the top bit down by the op index; the illegal op selects nothing.
    always_comb begin
        // NOTE: assigning a default before any condition keeps every path driven, so no latch is inferred.
        onehot = '0;
        if (op != OP_ILLEGAL) begin
            onehot = SEL_TOP >> op;
        end
    end

endmodule

// File: rtl/alu_seq_driver.sv
// Drives one command at a time through an external ALU and returns its result,
// with an error response for the illegal op or when the ALU never reports a result.
module alu_seq_driver
    import alu_pkg::*;
#(
    parameter int                  TIMEOUT      = 15,
    parameter logic [ALU_ST_W-1:0] RESULT_STATE = ALU_RESULT_STATE
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [DATA_W-1:0]   cmd_a,
    input  logic [DATA_W-1:0]   cmd_b,
    input  logic [OP_W-1:0]     cmd_op,
    output logic                alu_on,
    output logic [2:0]          alu_in_sel,
    output logic [DATA_W-1:0]   alu_num1,
    output logic [DATA_W-1:0]   alu_num2,
    output logic [SEL_W-1:0]    alu_out_sel,
    input  logic [DATA_W-1:0]   alu_out,
    input  logic [ALU_ST_W-1:0] alu_state,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_data,
    output logic                rsp_err,
    output logic                busy
);

    // Counter only has to reach TIMEOUT-1.
    localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [OP_W-1:0]     op_q;
    logic [CNT_W-1:0]    wait_cnt;
    logic [DATA_W-1:0]   data_q;
    logic                err_q;
    logic                illegal_q;   // current transaction never touched the ALU
    logic [SEL_W-1:0]    op_onehot;
    logic                cmd_hs;
    logic                result_hit;
    logic                timeout_hit;

    alu_op_decode u_op_decode (
        .op     (op_q),
        .onehot (op_onehot)
    );

    assign cmd_hs      = (state == ST_IDLE) && cmd_valid;
    assign result_hit  = (state == ST_WAIT) && (alu_state == RESULT_STATE);
    // Result is checked first wherever both are used, so a result on the last cycle wins.
    assign timeout_hit = (state == ST_WAIT) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign rsp_data = data_q;
    assign rsp_err  = err_q;

    // State register; reset drops any in-flight command.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state <= state_nxt;
        end
    end

    // Command latch, wait counter and response capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: operand and response registers are reset too, because they drive outputs that must read 0 out of reset.
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            wait_cnt  <= '0;
            data_q    <= '0;
            err_q     <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            if (cmd_hs) begin
                illegal_q <= (cmd_op == OP_ILLEGAL);
                if (cmd_op == OP_ILLEGAL) begin
                    data_q <= '0;
                    err_q  <= 1'b1;
                end else begin
                    a_q  <= cmd_a;
                    b_q  <= cmd_b;
                    op_q <= cmd_op;
                end
            end
            if (state == ST_LOAD) begin
                wait_cnt <= '0;
            end else if (result_hit) begin
                data_q <= alu_out;
                err_q  <= 1'b0;
            end else if (timeout_hit) begin
                data_q <= '0;
                err_q  <= 1'b1;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
        end
    end

    // Next state and state-decoded outputs; nothing here passes cmd_* straight to alu_*.
    always_comb begin
        state_nxt   = state;
        cmd_ready   = 1'b0;
        busy        = 1'b1;
        rsp_valid   = 1'b0;
        alu_on      = 1'b0;
        alu_in_sel  = IN_SEL_NONE;
        alu_num1    = '0;
        alu_num2    = '0;
        alu_out_sel = '0;
        unique case (state)
            ST_IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) begin
                    state_nxt = (cmd_op == OP_ILLEGAL) ? ST_RESP : ST_LOAD;
                end
            end
            ST_LOAD: begin
                alu_on      = 1'b1;
                alu_in_sel  = IN_SEL_LOAD;
                alu_num1    = a_q;
                alu_num2    = b_q;
                alu_out_sel = op_onehot;
                state_nxt   = ST_WAIT;
            end
            ST_WAIT: begin
                alu_on      = 1'b1;
                alu_in_sel  = IN_SEL_PERSIST;
                alu_num1    = a_q;
                alu_num2    = b_q;
                alu_out_sel = op_onehot;
                if (result_hit || timeout_hit) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (!illegal_q) begin
                    alu_on      = 1'b1;
                    alu_in_sel  = IN_SEL_PERSIST;
                    alu_num1    = a_q;
                    alu_num2    = b_q;
                    alu_out_sel = op_onehot;
                end
                if (rsp_ready) begin
                    state_nxt = illegal_q ? ST_IDLE : ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                alu_on     = 1'b1;
                alu_in_sel = IN_SEL_RESET;
                state_nxt  = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule

// File: doc/alu_seq_driver.md
ALU_SEQ_DRIVER -- requirements
Module: alu_seq_driver

Interface
REQ-001 Parameter TIMEOUT, default 15; maximum WAIT cycles before an error response.
REQ-002 Parameter RESULT_STATE, default 2'b11; ALU state code that means the result is valid.
REQ-003 clk  in  1  single clock; all state changes on the rising edge.
REQ-004 rst  in  1  asynchronous, active-low reset.
REQ-005 cmd_valid  in  1  command present.
REQ-006 cmd_ready  out  1  driver can accept a command.
REQ-007 cmd_a, cmd_b  in  8 each  operands.
REQ-008 cmd_op  in  3  operation index: 0..6 valid, 7 illegal.
REQ-009 alu_on  out  1  ALU enable.
REQ-010 alu_in_sel  out  3  100 = persist, 010 = load, 001 = reset, 000 = none.
REQ-011 alu_num1, alu_num2  out  8 each  operands to the ALU.
REQ-012 alu_out_sel  out  7  one-hot operation select to the ALU.
REQ-013 alu_out  in  8  ALU result.
REQ-014 alu_state  in  2  ALU current state.
REQ-015 rsp_valid  out  1  response present.
REQ-016 rsp_ready  in  1  consumer accepts the response.
REQ-017 rsp_data  out  8  captured result.
REQ-018 rsp_err  out  1  error flag: illegal op or timeout.
REQ-019 busy  out  1  high in every state except IDLE.

Function
REQ-020 FSM states SHALL be IDLE, LOAD, WAIT, RESP and CLEAR.
REQ-021 cmd_ready SHALL be 1 only in IDLE; a handshake is cmd_valid and cmd_ready both high on a rising edge.
REQ-022 On a handshake with a legal op, the driver SHALL latch cmd_a, cmd_b and cmd_op and enter LOAD.
REQ-023 On a handshake with cmd_op = 7, the driver SHALL enter RESP directly with rsp_err = 1 and rsp_data = 0x00; no ALU signal toggles.
REQ-024 In LOAD (exactly 1 cycle) the outputs SHALL be: alu_on = 1, alu_in_sel = 010, num1/num2 = latched operands, out_sel = decoded op; next state WAIT.
REQ-025 Op decode SHALL be: op n -> bit (6-n) set; op 0 = 1000000, op 6 = 0000001.
REQ-026 In WAIT the outputs SHALL be: alu_on = 1, alu_in_sel = 100, operands and out_sel held; a wait counter starts at 0 and increments each cycle.
REQ-027 In WAIT, when alu_state == RESULT_STATE, the driver SHALL capture alu_out into rsp_data, set rsp_err = 0 and enter RESP on that edge.
REQ-028 In WAIT, when the counter reaches TIMEOUT without RESULT_STATE, the driver SHALL enter RESP with rsp_err = 1 and rsp_data = 0x00.
REQ-029 If the result and the timeout occur in the same cycle, the result SHALL win.
REQ-030 In RESP, rsp_valid SHALL be 1, and rsp_data and rsp_err SHALL be held stable while rsp_ready = 0; alu_on = 1 and alu_in_sel = 100 after an ALU access, all ALU outputs 0 after an illegal op.
REQ-031 On a RESP handshake the driver SHALL enter CLEAR after an ALU access, or IDLE after an illegal op.
REQ-032 In CLEAR (exactly 1 cycle) the outputs SHALL be: alu_on = 1, alu_in_sel = 001, out_sel = 0; next state IDLE.
REQ-033 In IDLE all ALU outputs SHALL be 0.
REQ-034 Minimum legal-command latency SHALL be: handshake edge -> LOAD -> WAIT (result on first WAIT cycle) -> rsp_valid high 3 edges after the handshake.
REQ-035 cmd_valid SHALL be ignored outside IDLE; no command is buffered.

Reset
REQ-036 When rst = 0, the FSM SHALL enter IDLE asynchronously, including mid-operation; in-flight commands are dropped with no response.
REQ-037 Reset values SHALL be: all outputs 0 except cmd_ready = 1; wait counter 0.
REQ-038 The first command SHALL be accepted on the first rising edge after rst deasserts.

Structure
REQ-039 Package alu_pkg SHALL hold the state encoding (3-bit), the in_sel constants (PERSIST, LOAD, RESET, NONE), the ALU RESULT_STATE code and OP_ILLEGAL = 7.
REQ-040 Sub-module alu_op_decode SHALL hold the combinational 3-to-7 one-hot decode, with output 0 for op 7.
REQ-041 All FSM outputs SHALL be registered or decoded from the state only; no combinational path from cmd_* to alu_* outputs.

Verification
REQ-042 Legal command: a=0x57, b=0x1A, op=0; ALU model reaches state 11 after 2 WAIT cycles with out=0x71 -> LOAD shows in_sel 010, out_sel 1000000; rsp_data = 0x71, rsp_err = 0; then CLEAR in_sel 001.
REQ-043 Illegal op: op=7 -> rsp_valid on the next edge, rsp_err = 1, rsp_data = 0x00, alu_on never 1.
REQ-044 Timeout: ALU model never reaches 11 -> rsp_err = 1 after exactly 15 WAIT cycles.
REQ-045 Backpressure: rsp_ready low for 5 cycles with a=0x02, b=0x04, op=6 -> rsp_data stable, cmd_ready stays 0, out_sel 0000001 during WAIT.
REQ-046 Reset mid-WAIT: drive rst low -> all outputs 0 and cmd_ready 1 immediately; the next command completes normally.
REQ-047 Back-to-back: cmd_valid held high for 2 commands -> second accepted only after CLEAR; exactly 2 responses, in order.
